data_mem_arbiter: RTL
=====================

// Module: data_mem_arbiter
// PURPOSE
//  Two-port arbiter/sequencer in front of the single-port data memory (cs/we, 1-cycle registered read).
//  Port 0 = CPU load/store stage, port 1 = debug/DMA loader. Grants one access at a time, drives
//  memory cs/we/address/data_in, captures read data, and returns a one-cycle ack with read data.
//  Out-of-range addresses are rejected without touching the memory.
// PARAMETERS
//  DATA_WIDTH  32     data word width
//  ADDR_WIDTH  13     word address width
//  MEM_DEPTH   8192   implemented words; addr >= MEM_DEPTH is out of range
//  FIXED_PRIO  0      0 = round-robin; 1 = port 0 always wins a tie
// PORTS
//  clk        in   1           clock, all flops on rising edge
//  rst_n      in   1           asynchronous active-low reset
//  req0/req1  in   1           request, level; held with addrN/weN/wdataN stable until ackN
//  addr0/1    in   ADDR_WIDTH  word address
//  we0/we1    in   1           1 = write, 0 = read
//  wdata0/1   in   DATA_WIDTH  write data
//  gnt0/gnt1  out  1           registered one-hot grant, high ISSUE..RESP of own transaction
//  ack0/ack1  out  1           one-cycle completion pulse (RESP state)
//  err0/err1  out  1           with ack: address out of range, no memory access made
//  rdata      out  DATA_WIDTH  read data, valid with ack of a read; 0 for writes/err
//  busy       out  1           state != IDLE
//  mem_cs     out  1           memory chip select (registered)
//  mem_we     out  1           memory write enable (registered)
//  mem_addr   out  ADDR_WIDTH  memory address (registered)
//  mem_wdata  out  DATA_WIDTH  memory data_in (registered)
//  mem_rdata  in   DATA_WIDTH  memory data_out
// BEHAVIOUR
//  Reset (async, immediate): state=IDLE; all outputs 0; last_grant=1 (port 0 wins first tie).
//  States: IDLE -> ISSUE -> (read: WAIT) -> RESP -> IDLE. Requests sampled only in IDLE.
//  IDLE: no req: stay. One req: pick it. Both: FIXED_PRIO=1 -> port 0; else port != last_grant.
//   On leaving IDLE: latch winner, addr, we, wdata; set gntN; update last_grant.
//   If latched addr >= MEM_DEPTH: go straight to RESP with err, mem_cs stays 0.
//   Else go ISSUE with mem_cs=1, mem_we=we, mem_addr/mem_wdata = latched values.
//  ISSUE (1 cycle): memory acts on edge ending ISSUE. mem_cs/mem_we cleared on that edge.
//   write -> RESP; read -> WAIT.
//  WAIT (1 cycle): mem_rdata valid; captured into rdata on edge ending WAIT -> RESP.
//  RESP (1 cycle): ackN=1 (errN if rejected); rdata valid for reads. Edge ending RESP: ack, err,
//   gnt, rdata cleared to 0 -> IDLE.
//  Latency (req high at IDLE edge E0 to ack cycle): read 3 cycles, write 2, err 1.
//  Requester must drop req on edge ending its RESP; req still high in IDLE = new request.
//  Input changes on non-granted port while busy are ignored; granted port inputs not re-read.
//  mem_cs never asserted two consecutive cycles; mem_we only with mem_cs.
//  At most one of ack0/ack1, gnt0/gnt1 high in any cycle.
//  rst_n low mid-transaction: mem_cs/mem_we drop immediately, no ack issued; write in ISSUE is
//   abandoned if reset precedes the ending edge.
//  addr = MEM_DEPTH-1 is valid; addr = MEM_DEPTH is err (only when MEM_DEPTH < 2**ADDR_WIDTH).
// TESTING
//  1 Port0 write 0xDEADBEEF @0x010, then read @0x010 -> ack0 2 cycles / 3 cycles, rdata=0xDEADBEEF.
//  2 req0,req1 both high from reset, held, RR -> grants 0,1,0,1; FIXED_PRIO=1 -> port 0 only.
//  3 Port1 read while port0 busy writing -> port1 granted next IDLE, port0 inputs changes ignored.
//  4 MEM_DEPTH=4096, read @0x1000 -> ack1+err1 1 cycle later, rdata=0, mem_cs never high;
//    read @0x0FFF -> normal ack, no err.
//  5 rst_n low during ISSUE of write 0x12345678 @0x020 -> outputs 0 immediately, @0x020 unchanged.
//  6 Checkers: one-hot gnt/ack, mem_cs pulse width 1, rdata=0 outside read RESP, busy==(state!=IDLE).

Source files
------------

// File: rtl/data_mem_arbiter.sv
// Two-port arbiter/sequencer in front of a single-port data memory with a 1-cycle registered read.
// Grants one access at a time, rejects out-of-range addresses, and returns a one-cycle ack.
module data_mem_arbiter #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 13,
  parameter int unsigned MEM_DEPTH  = 8192,
  parameter int unsigned FIXED_PRIO = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req0,
  input  logic                  req1,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic                  we0,
  input  logic                  we1,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  gnt0,
  output logic                  gnt1,
  output logic                  ack0,
  output logic                  ack1,
  output logic                  err0,
  output logic                  err1,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  busy,
  output logic                  mem_cs,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  // One extra bit so MEM_DEPTH == 2**ADDR_WIDTH still compares correctly.
  localparam logic [ADDR_WIDTH:0] DepthLimit = (ADDR_WIDTH+1)'(MEM_DEPTH);

  state_e                state_q, state_d;
  logic [1:0]            gnt_q, gnt_d;
  logic [1:0]            ack_q, ack_d;
  logic [1:0]            err_q, err_d;
  logic                  we_q, we_d;
  logic                  last_grant_q, last_grant_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  mem_cs_q, mem_cs_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;

  logic                  pick;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic                  sel_we;
  logic                  out_of_range;

  always_comb begin
    if (req0 && req1) begin
      pick = (FIXED_PRIO != 0) ? 1'b0 : ~last_grant_q;
    end else begin
      pick = req1;
    end
    sel_addr     = pick ? addr1 : addr0;
    sel_wdata    = pick ? wdata1 : wdata0;
    sel_we       = pick ? we1 : we0;
    out_of_range = {1'b0, sel_addr} >= DepthLimit;
  end

  always_comb begin
    state_d      = state_q;
    gnt_d        = gnt_q;
    ack_d        = ack_q;
    err_d        = err_q;
    we_d         = we_q;
    last_grant_d = last_grant_q;
    rdata_d      = rdata_q;
    mem_cs_d     = 1'b0;
    mem_we_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;

    unique case (state_q)
      StIdle: begin
        if (req0 || req1) begin
          gnt_d        = pick ? 2'b10 : 2'b01;
          we_d         = sel_we;
          last_grant_d = pick;
          if (out_of_range) begin
            state_d = StResp;
            ack_d   = pick ? 2'b10 : 2'b01;
            err_d   = pick ? 2'b10 : 2'b01;
            rdata_d = '0;
          end else begin
            state_d     = StIssue;
            mem_cs_d    = 1'b1;
            mem_we_d    = sel_we;
            mem_addr_d  = sel_addr;
            mem_wdata_d = sel_wdata;
          end
        end
      end
      StIssue: begin
        if (we_q) begin
          state_d = StResp;
          ack_d   = gnt_q;
        end else begin
          state_d = StWait;
        end
      end
      StWait: begin
        state_d = StResp;
        ack_d   = gnt_q;
        rdata_d = mem_rdata;
      end
      StResp: begin
        state_d = StIdle;
        gnt_d   = 2'b00;
        ack_d   = 2'b00;
        err_d   = 2'b00;
        rdata_d = '0;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      gnt_q        <= 2'b00;
      ack_q        <= 2'b00;
      err_q        <= 2'b00;
      we_q         <= 1'b0;
      last_grant_q <= 1'b1;
      rdata_q      <= '0;
      mem_cs_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      gnt_q        <= gnt_d;
      ack_q        <= ack_d;
      err_q        <= err_d;
      we_q         <= we_d;
      last_grant_q <= last_grant_d;
      rdata_q      <= rdata_d;
      mem_cs_q     <= mem_cs_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end

  assign gnt0      = gnt_q[0];
  assign gnt1      = gnt_q[1];
  assign ack0      = ack_q[0];
  assign ack1      = ack_q[1];
  assign err0      = err_q[0];
  assign err1      = err_q[1];
  assign rdata     = rdata_q;
  assign busy      = (state_q != StIdle);
  assign mem_cs    = mem_cs_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule
